// File: rtl/arbiter_rr8.sv
// arbiter_rr8: 8-way round-robin arbiter with a bounded hold time per grant
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req[7:0]    request vector, bit i held high while requester i needs the resource
//   grant_valid a grant is active this cycle (registered)
//   grant_idx   binary index of the granted requester (registered, held after release)
//   grant[7:0]  one-hot decode of grant_idx when grant_valid, else zero
module arbiter_rr8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [7:0] grant
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, idx_n, next_win;
  logic [3:0] hold_cnt, hold_n;
  logic valid_n, others, at_max;
  // First requester found scanning s, s+1, ... with 3-bit wraparound.
  // Scanning from the far end lets the nearest hit overwrite later ones.
  function automatic logic [2:0] win(input logic [7:0] r, input logic [2:0] s);
    win = s;
    for (int i = 7; i >= 0; i--) if (r[s + 3'(i)]) win = s + 3'(i);
  endfunction
  assign others   = |(req & ~(8'b1 << grant_idx));
  assign at_max   = hold_cnt == 4'(MAX_HOLD);
  assign next_win = win(req, grant_idx + 3'd1);
  assign grant    = grant_valid ? 8'b1 << grant_idx : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= 3'd0;
      ptr         <= 3'd0;
      hold_cnt    <= 4'd0;
    end else begin
      state       <= state_n;
      grant_valid <= valid_n;
      grant_idx   <= idx_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
    end
  // A grant ends on release or on forced rotation; either way the pointer
  // moves past the old owner and any other pending requester takes over
  // on the same edge, so there is no idle bubble between owners.
  always_comb begin
    state_n = state;
    valid_n = grant_valid;
    idx_n   = grant_idx;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        valid_n = 1'b1;
        idx_n   = win(req, ptr);
        hold_n  = 4'd1;
      end
    end else if (!req[grant_idx] || (at_max && others)) begin
      ptr_n  = grant_idx + 3'd1;
      hold_n = others ? 4'd1 : 4'd0;
      if (others) idx_n = next_win;
      else begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    end else if (!at_max) hold_n = hold_cnt + 4'd1;
  end
endmodule

// File: tb/tb_arbiter_rr8.sv
// tb_arbiter_rr8: randomized and directed checks of arbiter_rr8 against a behavioural model
module tb_arbiter_rr8;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic gv, gv1;
  logic [2:0] gi, gi1;
  logic [7:0] g, g1;
  int n_checks = 0;
  int n_fail = 0;
  int m_busy, m_g, m_cnt, m_ptr;
  arbiter_rr8 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .req(req),
    .grant_valid(gv), .grant_idx(gi), .grant(g));
  arbiter_rr8 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .req(req),
    .grant_valid(gv1), .grant_idx(gi1), .grant(g1));
  always #5 clk = ~clk;
  function automatic int find(input logic [7:0] r, input int s);
    for (int k = 0; k < 8; k++) if (r[(s + k) % 8]) return (s + k) % 8;
    return -1;
  endfunction
  function automatic logic [7:0] m_grant();
    return m_busy ? 8'(1 << m_g) : 8'h00;
  endfunction
  task automatic model_reset();
    m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
  endtask
  task automatic model_step();
    int others;
    others = $countones(req) - (req[m_g] ? 1 : 0);
    if (!m_busy) begin
      if (req != 0) begin m_busy = 1; m_g = find(req, m_ptr); m_cnt = 1; end
    end else if (!req[m_g] || (m_cnt == MH && others > 0)) begin
      m_ptr = (m_g + 1) % 8;
      if (others > 0) begin m_g = find(req, m_ptr); m_cnt = 1; end
      else m_busy = 0;
    end else if (m_cnt < MH) m_cnt++;
  endtask
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'h00;
    model_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({gv, gi, g} !== {1'b0, 3'd0, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got v=%0b idx=%0d grant=%h, want v=0 idx=0 grant=00", k, gv, gi, g);
      end
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({gv, gi, g} !== {1'b1, 3'd0, 8'h01}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got v=%0b idx=%0d grant=%h, want v=1 idx=0 grant=01", gv, gi, g);
    end
  endtask
  task automatic test_single();
    do_reset();
    req = 8'h08;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({gv, gi, g} !== {1'b1, 3'd3, 8'h08}) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: got v=%0b idx=%0d grant=%h, want v=1 idx=3 grant=08", k, gv, gi, g);
      end
    end
    req = 8'h00;
    step();
    n_checks++;
    if ({gv, gi, g} !== {1'b0, 3'd3, 8'h00}) begin
      n_fail++;
      $display("FAIL single_release: got v=%0b idx=%0d grant=%h, want v=0 idx=3 grant=00", gv, gi, g);
    end
  endtask
  task automatic test_round_robin();
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 33; k++) begin
      step();
      n_checks++;
      if (!gv || gi !== 3'((k / 4) % 8) || g !== 8'(1 << ((k / 4) % 8))) begin
        n_fail++;
        $display("FAIL round_robin[%0d]: got v=%0b idx=%0d grant=%h, want v=1 idx=%0d", k, gv, gi, g, (k / 4) % 8);
      end
    end
  endtask
  task automatic test_wrap();
    do_reset();
    req = 8'h20;
    step();
    req = 8'h21;
    step();
    n_checks++;
    if ({gv, gi, g} !== {1'b1, 3'd5, 8'h20}) begin
      n_fail++;
      $display("FAIL wrap_hold: got v=%0b idx=%0d grant=%h, want v=1 idx=5 grant=20", gv, gi, g);
    end
    req = 8'h01;
    step();
    n_checks++;
    if ({gv, gi, g} !== {1'b1, 3'd0, 8'h01}) begin
      n_fail++;
      $display("FAIL wrap_handoff: got v=%0b idx=%0d grant=%h, want v=1 idx=0 grant=01", gv, gi, g);
    end
  endtask
  task automatic test_saturation();
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({gv, gi, g} !== {1'b1, 3'd2, 8'h04}) begin
        n_fail++;
        $display("FAIL sat_hold[%0d]: got v=%0b idx=%0d grant=%h, want v=1 idx=2 grant=04", k, gv, gi, g);
      end
    end
    req = 8'h44;
    step();
    n_checks++;
    if ({gv, gi, g} !== {1'b1, 3'd6, 8'h40}) begin
      n_fail++;
      $display("FAIL sat_rotate: got v=%0b idx=%0d grant=%h, want v=1 idx=6 grant=40", gv, gi, g);
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    step();
    n_checks++;
    if (g !== 8'h10) begin
      n_fail++;
      $display("FAIL async_pre: got grant=%h, want 10", g);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({gv, gi, g} !== {1'b0, 3'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_abort: got v=%0b idx=%0d grant=%h, want v=0 idx=0 grant=00", gv, gi, g);
    end
    req = 8'h30;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({gv, gi, g} !== {1'b1, 3'd4, 8'h10}) begin
      n_fail++;
      $display("FAIL async_after: got v=%0b idx=%0d grant=%h, want v=1 idx=4 grant=10", gv, gi, g);
    end
  endtask
  task automatic test_max_hold1();
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      step();
      n_checks++;
      if (!gv1 || gi1 !== 3'(k % 8) || g1 !== 8'(1 << (k % 8))) begin
        n_fail++;
        $display("FAIL max_hold1[%0d]: got v=%0b idx=%0d grant=%h, want v=1 idx=%0d", k, gv1, gi1, g1, k % 8);
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req = req ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 24) == 0) req = 8'h00;
      step();
      n_checks++;
      if ({gv, gi, g} !== {m_busy[0], 3'(m_g), m_grant()} || !$onehot0(g) || !$onehot0(g1)) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%h got v=%0b idx=%0d grant=%h grant1=%h, want v=%0d idx=%0d grant=%h",
                 k, req, gv, gi, g, g1, m_busy, m_g, m_grant());
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_saturation();
    test_async_reset();
    test_max_hold1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
